// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants for the register-file writeback scheduler:
// geometry of the register file and the requester-select encoding.
package regfile_wb_sched_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    // Requester-select encoding; also the bit position of each side in req/gnt.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/regfile_wb_sched_arb.sv
// Two-input round-robin arbiter. rr_ptr names the side that wins the next contest;
// after a contested transfer it moves to the loser so neither side can starve.
module rr_arb2
    import regfile_wb_sched_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       xfer,
    output logic [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_ptr == SEL_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= SEL_A;
        end else if (xfer && (&req)) begin
            rr_ptr <= ~rr_ptr;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates ALU (A) and load (B) results onto the single
// register-file write port and tracks pending writes for decode hazard detection.
module regfile_wb_sched #(
    parameter int DW   = regfile_wb_sched_pkg::DW,
    parameter int AW   = regfile_wb_sched_pkg::AW,
    parameter int NREG = regfile_wb_sched_pkg::NREG
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          claim_valid,
    input  logic [AW-1:0] claim_reg,
    input  logic [AW-1:0] RR1,
    input  logic [AW-1:0] RR2,
    output logic          hz1,
    output logic          hz2,
    output logic          RegWrite,
    output logic [AW-1:0] WR,
    output logic [DW-1:0] WD
);
    import regfile_wb_sched_pkg::*;

    // Handshake: a transfer happens at a posedge where valid && ready; ready is
    // only ever raised for a valid requester, and the output stage never stalls.
    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            xfer;
    logic [AW-1:0]   sel_reg;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    assign req = {b_valid, a_valid};

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .xfer  (xfer),
        .gnt   (gnt)
    );

    assign a_ready  = gnt[SEL_A];
    assign b_ready  = gnt[SEL_B];
    assign xfer     = |gnt;
    assign sel_reg  = gnt[SEL_B] ? b_reg  : a_reg;
    assign sel_data = gnt[SEL_B] ? b_data : a_data;

    // Register 0 is accepted and latched but never enabled onto the file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            RegWrite <= 1'b0;
            WR       <= '0;
            WD       <= '0;
        end else begin
            RegWrite <= xfer && (sel_reg != REG_ZERO);
            if (xfer) begin
                WR <= sel_reg;
                WD <= sel_data;
            end
        end
    end

    // The claim is applied after the clear so a re-claim on the retiring edge wins.
    always_comb begin
        pend_nxt = pend;
        if (RegWrite) begin
            pend_nxt[WR] = 1'b0;
        end
        if (claim_valid && (claim_reg != REG_ZERO)) begin
            pend_nxt[claim_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign hz1 = pend[RR1];
    assign hz2 = pend[RR2];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios from the test plan followed by a
// randomized run checked against a behavioural model of grants, writes and hazards.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          a_valid, b_valid, claim_valid;
    logic [AW-1:0] a_reg, b_reg, claim_reg, RR1, RR2, WR;
    logic [DW-1:0] a_data, b_data, WD;
    logic          a_ready, b_ready, hz1, hz2, RegWrite;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit            pend_m [NREG];
    bit            favour_b;
    bit            rw_m;
    logic [AW-1:0] wr_m;
    logic [DW-1:0] wd_m;
    logic [AW+DW-1:0] exp_q[$];

    regfile_wb_sched dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .RR1         (RR1),
        .RR2         (RR2),
        .hz1         (hz1),
        .hz2         (hz2),
        .RegWrite    (RegWrite),
        .WR          (WR),
        .WD          (WD)
    );

    always #5 clock = ~clock;

    task automatic set_idle();
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        claim_valid = 1'b0; claim_reg = '0;
        RR1 = '0; RR2 = '0;
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        set_idle();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < NREG; i++) pend_m[i] = 1'b0;
        favour_b = 1'b0;
        rw_m = 1'b0; wr_m = '0; wd_m = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        set_idle();
        a_valid = 1'b1; a_reg = 5'd2; b_valid = 1'b1; b_reg = 5'd3;
        claim_valid = 1'b1; claim_reg = 5'd6; RR1 = 5'd6;
        repeat (3) begin
            @(negedge clock);
            n_cmp++;
            if ({a_ready, b_ready, hz1} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_comb: ready/hz = %b, required 000", {a_ready, b_ready, hz1});
            end
        end
        @(posedge clock); #1;
        set_idle();
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({RegWrite, WR, WD, hz1, hz2, a_ready, b_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: RegWrite=%b WR=%0d WD=%h hz=%b%b rdy=%b%b, required all 0",
                     RegWrite, WR, WD, hz1, hz2, a_ready, b_ready);
        end
    endtask

    task automatic test_single_a();
        apply_reset();
        @(posedge clock); #1;
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234;
        @(negedge clock);
        n_cmp++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_a_grant: a_ready/b_ready=%b, required 10", {a_ready, b_ready});
        end
        @(posedge clock); #1;
        set_idle();
        @(negedge clock);
        n_cmp++;
        if (RegWrite !== 1'b1 || WR !== 5'd5 || WD !== 32'h1234) begin
            n_bad++;
            $display("FAIL single_a_write: RegWrite=%b WR=%0d WD=%h, required 1 5 00001234", RegWrite, WR, WD);
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_cmp++;
        if (RegWrite !== 1'b0 || WR !== 5'd5 || WD !== 32'h1234) begin
            n_bad++;
            $display("FAIL single_a_hold: RegWrite=%b WR=%0d WD=%h, required 0 5 00001234", RegWrite, WR, WD);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] exp_wr;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (i < 4) begin
                a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hA000 + i;
                b_valid = 1'b1; b_reg = 5'd7; b_data = 32'hB000 + i;
            end else begin
                set_idle();
            end
            @(negedge clock);
            if (i < 4) begin
                n_cmp++;
                if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                    n_bad++;
                    $display("FAIL contention_grant[%0d]: a/b ready=%b%b, required %b%b",
                             i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
                end
            end
            if (i > 0) begin
                exp_wr = ((i - 1) % 2 == 0) ? 5'd3 : 5'd7;
                n_cmp++;
                if (RegWrite !== 1'b1 || WR !== exp_wr) begin
                    n_bad++;
                    $display("FAIL contention_write[%0d]: RegWrite=%b WR=%0d, required 1 %0d", i, RegWrite, WR, exp_wr);
                end
            end
        end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            @(posedge clock); #1;
            set_idle();
            RR1 = 5'd9; RR2 = 5'd10;
            case (c)
                0: begin claim_valid = 1'b1; claim_reg = 5'd9; end
                1: begin b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hC0DE; end
                4: begin claim_valid = 1'b1; claim_reg = 5'd9;
                         b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hBEEF; end
                5: begin claim_valid = 1'b1; claim_reg = 5'd9; end
                default: ;
            endcase
            @(negedge clock);
            n_cmp++;
            // Expected hz1 per cycle: claimed at edge 1, retired at edge 3,
            // re-claimed at edges 5 and 6 (the second one collides with the clear).
            if (hz1 !== (c inside {1, 2, 5, 6}) || hz2 !== 1'b0) begin
                n_bad++;
                $display("FAIL scoreboard_hz[%0d]: hz1=%b hz2=%b, required %b 0", c, hz1, hz2, c inside {1, 2, 5, 6});
            end
            if (c == 2 || c == 5) begin
                n_cmp++;
                if (RegWrite !== 1'b1 || WR !== 5'd9) begin
                    n_bad++;
                    $display("FAIL scoreboard_write[%0d]: RegWrite=%b WR=%0d, required 1 9", c, RegWrite, WR);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        @(posedge clock); #1;
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF_FFFF;
        claim_valid = 1'b1; claim_reg = 5'd0; RR1 = 5'd0;
        @(negedge clock);
        n_cmp++;
        if (a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_grant: a_ready=%b, required 1", a_ready);
        end
        @(posedge clock); #1;
        set_idle();
        @(negedge clock);
        n_cmp++;
        if (RegWrite !== 1'b0 || WR !== 5'd0 || WD !== 32'hFFFF_FFFF || hz1 !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_write: RegWrite=%b WR=%0d WD=%h hz1=%b, required 0 0 ffffffff 0", RegWrite, WR, WD, hz1);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(posedge clock); #1;
        claim_valid = 1'b1; claim_reg = 5'd4; RR1 = 5'd4;
        @(posedge clock); #1;
        claim_valid = 1'b0;
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h4444;
        @(posedge clock); #1;
        a_valid = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (RegWrite !== 1'b1 || hz1 !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre: RegWrite=%b hz1=%b, required 1 1", RegWrite, hz1);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (RegWrite !== 1'b0 || hz1 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_drop: RegWrite=%b hz1=%b, required 0 0", RegWrite, hz1);
        end
        @(posedge clock); #1;
        set_idle();
        reset = 1'b1;
    endtask

    task automatic test_random();
        bit a_hold = 0, b_hold = 0;
        bit ea, eb;
        logic [AW+DW-1:0] got;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clock); #1;
            if (a_hold) begin
                if ($urandom_range(0, 9) == 0) a_valid = 1'b0;
            end else begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_reg = AW'($urandom_range(0, NREG - 1)); a_data = $urandom;
            end
            if (b_hold) begin
                if ($urandom_range(0, 9) == 0) b_valid = 1'b0;
            end else begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_reg = AW'($urandom_range(0, NREG - 1)); b_data = $urandom;
            end
            claim_valid = $urandom_range(0, 1);
            claim_reg = AW'($urandom_range(0, NREG - 1));
            RR1 = ($urandom_range(0, 3) == 0) ? a_reg : AW'($urandom_range(0, NREG - 1));
            RR2 = ($urandom_range(0, 3) == 0) ? b_reg : AW'($urandom_range(0, NREG - 1));
            @(negedge clock);

            // Lone requester wins; a contest goes to the favoured side.
            ea = a_valid && (!b_valid || !favour_b);
            eb = b_valid && (!a_valid || favour_b);
            n_cmp++;
            if (a_ready !== ea || b_ready !== eb) begin
                n_bad++;
                $display("FAIL rand_grant[%0d]: a/b ready=%b%b, required %b%b", cyc, a_ready, b_ready, ea, eb);
            end
            n_cmp++;
            if (hz1 !== pend_m[RR1] || hz2 !== pend_m[RR2]) begin
                n_bad++;
                $display("FAIL rand_hz[%0d]: hz1=%b hz2=%b, required %b %b", cyc, hz1, hz2, pend_m[RR1], pend_m[RR2]);
            end
            n_cmp++;
            if (RegWrite !== rw_m || WR !== wr_m || WD !== wd_m) begin
                n_bad++;
                $display("FAIL rand_port[%0d]: RegWrite=%b WR=%0d WD=%h, required %b %0d %h",
                         cyc, RegWrite, WR, WD, rw_m, wr_m, wd_m);
            end
            if (RegWrite === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_queue[%0d]: write WR=%0d with nothing expected", cyc, WR);
                end else begin
                    got = exp_q.pop_front();
                    if ({WR, WD} !== got) begin
                        n_bad++;
                        $display("FAIL rand_queue[%0d]: WR/WD=%0d/%h, required %0d/%h",
                                 cyc, WR, WD, got[AW+DW-1:DW], got[DW-1:0]);
                    end
                end
            end

            // Advance the model across the coming edge.
            if (rw_m) pend_m[wr_m] = 1'b0;
            if (claim_valid && claim_reg != 0) pend_m[claim_reg] = 1'b1;
            if (ea || eb) begin
                wr_m = ea ? a_reg : b_reg;
                wd_m = ea ? a_data : b_data;
                rw_m = (wr_m != 0);
                if (rw_m) exp_q.push_back({wr_m, wd_m});
            end else begin
                rw_m = 1'b0;
            end
            if (a_valid && b_valid) favour_b = ~favour_b;
            a_hold = a_valid && !ea;
            b_hold = b_valid && !eb;
        end
        @(posedge clock); #1;
        set_idle();
        @(negedge clock);
        if (RegWrite === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_drain: %0d expected writes never appeared, required 0", exp_q.size());
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_single_a();
        test_contention();
        test_scoreboard();
        test_zero_reg();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
